magnitude_dispatch: RTL

MAGNITUDE_DISPATCH -- requirements
Module: magnitude_dispatch

---
 rtl/magnitude_dispatch.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/magnitude_dispatch.sv
// ============================================================================
//  Module      : magnitude_dispatch
//  Description : Buffers X/Y filter results in a 2-entry FIFO, issues them one
//                at a time to an external square-root engine, waits for the
//                engine's rising done edge (or a timeout) and hands the
//                magnitude downstream with a valid/ready handshake.
//                Optional macro MAGNITUDE_THRESHOLD_EN binarizes the result
//                against THRESHOLD (8'hFF at or above, 8'h00 below).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module magnitude_dispatch #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int THRESHOLD      = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  output logic       sqrt_start,
  output logic [7:0] sqrt_x,
  output logic [7:0] sqrt_y,
  input  logic       sqrt_ready,
  input  logic [7:0] sqrt_root,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_root,
  output logic       out_timeout
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  // Parameter sanity: a zero timeout would make the counter meaningless and
  // a threshold outside 0..256 cannot be compared against an 8-bit root.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("magnitude_dispatch: TIMEOUT_CYCLES must be at least 1");
  end
  if ((THRESHOLD < 0) || (THRESHOLD > 256)) begin : g_bad_threshold
    $error("magnitude_dispatch: THRESHOLD must lie in 0..256");
  end

  state_t             r_state;
  state_t             w_state_next;

  logic [7:0]         r_fx [0:1];
  logic [7:0]         r_fy [0:1];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_ready_q;
  logic [7:0]         r_sqrt_x;
  logic [7:0]         r_sqrt_y;
  logic [7:0]         r_out_root;
  logic               r_out_timeout;

  logic               w_push;
  logic               w_pop;
  logic               w_done;
  logic               w_tmo;
  logic [7:0]         w_result;

  assign in_ready    = (r_count != 2'd2);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != 2'd0);

  // Only a fresh 0->1 transition counts; a level left high by a previous
  // request (or held high across ISSUE) is ignored.
  assign w_done      = (r_state == S_WAIT) & sqrt_ready & ~r_ready_q;
  // Fires on the TIMEOUT_CYCLES-th WAIT cycle.
  assign w_tmo       = (r_state == S_WAIT) && (r_cnt >= c_CNT_LAST);

  assign sqrt_x      = r_sqrt_x;
  assign sqrt_y      = r_sqrt_y;
  assign out_root    = r_out_root;
  assign out_timeout = r_out_timeout;

`ifdef MAGNITUDE_THRESHOLD_EN
  assign w_result = (32'(sqrt_root) >= THRESHOLD) ? 8'hFF : 8'h00;
`else
  assign w_result = sqrt_root;
`endif

  // Input FIFO: 1-bit pointers wrap modulo 2, count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_fx[0] <= 8'h00;
      r_fx[1] <= 8'h00;
      r_fy[0] <= 8'h00;
      r_fy[1] <= 8'h00;
    end else begin
      if (w_push) begin
        r_fx[r_wptr] <= in_x;
        r_fy[r_wptr] <= in_y;
        r_wptr       <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the state-derived strobes.
  always_comb begin
    w_state_next = r_state;
    sqrt_start   = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 2'd0) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sqrt_start   = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_done || w_tmo) begin
          w_state_next = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, timeout counting and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_q     <= 1'b0;
      r_cnt         <= '0;
      r_sqrt_x      <= 8'h00;
      r_sqrt_y      <= 8'h00;
      r_out_root    <= 8'h00;
      r_out_timeout <= 1'b0;
    end else begin
      r_ready_q <= sqrt_ready;
      if (w_pop) begin
        r_sqrt_x <= r_fx[r_rptr];
        r_sqrt_y <= r_fy[r_rptr];
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Completion takes priority over a coincident timeout.
      if (w_done) begin
        r_out_root    <= w_result;
        r_out_timeout <= 1'b0;
      end else if (w_tmo) begin
        r_out_root    <= 8'hFF;
        r_out_timeout <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
